// File: rtl/mux4_rr_arbiter.sv
// Registered round-robin arbiter that owns the select pair of a gate-level 4:1 mux.
// Define MUX_ARB_HOLD_EN to let a winner keep the mux for up to HOLD cycles.

module mux4_gate (
    input  logic s0,
    input  logic s1,
    input  logic s2,
    input  logic s3,
    input  logic x0,
    input  logic x1,
    output logic y
);
    logic nx0;
    logic nx1;
    logic t0;
    logic t1;
    logic t2;
    logic t3;

    assign nx0 = ~x0;
    assign nx1 = ~x1;
    assign t0  = nx1 & nx0 & s0;
    assign t1  = nx1 &  x0 & s1;
    assign t2  =  x1 & nx0 & s2;
    assign t3  =  x1 &  x0 & s3;
    assign y   = t0 | t1 | t2 | t3;
endmodule

module mux4_rr_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       out,
    output logic       valid,
    output logic       busy
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD);

    state_t     state;
    logic [1:0] last;
    logic [3:0] cnt;

    logic [1:0] search_ptr;
    logic       win_found;
    logic [1:0] win_idx;
    logic       release_now;
    logic       mux_y;

    // The mux sees the registered select, so its output pairs with the grant
    // issued on the previous edge.
    mux4_gate u_mux (
        .s0 (d[0]),
        .s1 (d[1]),
        .s2 (d[2]),
        .s3 (d[3]),
        .x0 (sel[0]),
        .x1 (sel[1]),
        .y  (mux_y)
    );

    // On a release edge the pointer becomes sel, so searching from sel
    // directly gives the same-edge re-arbitration result.
    assign search_ptr = (state == GRANT) ? sel : last;

    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = search_ptr;
        cand      = search_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = search_ptr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef MUX_ARB_HOLD_EN
    assign release_now = !req[sel] || (cnt >= HOLD_LIM);
`else
    assign release_now = 1'b1;
`endif

    assign busy = (state == GRANT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            out   <= 1'b0;
            valid <= 1'b0;
            last  <= 2'd3;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (win_found) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << win_idx;
                        sel   <= win_idx;
                        cnt   <= 4'd1;
                    end else begin
                        gnt <= 4'b0000;
                    end
                end
                GRANT: begin
                    out   <= mux_y;
                    valid <= 1'b1;
                    if (release_now) begin
                        last <= sel;
                        if (win_found) begin
                            gnt <= 4'b0001 << win_idx;
                            sel <= win_idx;
                            cnt <= 4'd1;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end
                    end else if (cnt < HOLD_LIM) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
